// File: rtl/m6502_bus_arbiter.sv
// rtl/m6502_bus_arbiter.sv - CPU/DMA arbiter for a shared 6502-style memory bus
module m6502_bus_arbiter #(
  parameter int DMA_BURST_MAX = 4,
  parameter int ACK_TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd_req,
  input  logic        cpu_wr_en,
  input  logic [7:0]  cpu_wr_data,
  output logic [7:0]  cpu_rd_data,
  output logic        cpu_ready,
  input  logic [15:0] dma_addr,
  input  logic        dma_rd_req,
  input  logic        dma_wr_en,
  input  logic [7:0]  dma_wr_data,
  output logic [7:0]  dma_rd_data,
  output logic        dma_ready,
  output logic [15:0] mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [7:0]  mem_wr_data,
  input  logic [7:0]  mem_rd_data,
  input  logic        mem_ack,
  output logic        grant_dma,
  output logic        timeout_err
);

  localparam int RUN_W = ($clog2(DMA_BURST_MAX + 1) > 3) ? $clog2(DMA_BURST_MAX + 1) : 3;
  localparam int TO_W  = ($clog2(ACK_TIMEOUT + 1) > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_ACK} state_t;

  state_t            state;
  logic              win_dma;
  logic [RUN_W-1:0]  run_cnt;
  logic [TO_W-1:0]   to_cnt;

  logic              cpu_vld, cpu_wr_q;
  logic [15:0]       cpu_addr_q;
  logic [7:0]        cpu_data_q;
  logic              dma_vld, dma_wr_q;
  logic [15:0]       dma_addr_q;
  logic [7:0]        dma_data_q;

  logic busy, timeout_hit, finish, cpu_done, dma_done, cpu_pend, pick_dma, win_wr;

  // Access bookkeeping: what finishes this cycle and who is still waiting for the bus
  assign busy        = (state != IDLE);
  assign timeout_hit = busy && !mem_ack && (to_cnt == TO_W'(ACK_TIMEOUT - 1));
  assign finish      = busy && (mem_ack || timeout_hit);
  assign cpu_done    = finish && !win_dma;
  assign dma_done    = finish && win_dma;
  assign cpu_pend    = cpu_vld && !(busy && !win_dma);
  assign pick_dma    = dma_vld && !(cpu_vld && (run_cnt == RUN_W'(DMA_BURST_MAX)));
  assign win_wr      = win_dma ? dma_wr_q : cpu_wr_q;

  assign cpu_ready   = ~cpu_vld;
  assign dma_ready   = ~dma_vld;

  // Request slots; a port whose access finishes on this edge may refill its slot at once
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_vld    <= 1'b0;
      cpu_wr_q   <= 1'b0;
      cpu_addr_q <= '0;
      cpu_data_q <= '0;
      dma_vld    <= 1'b0;
      dma_wr_q   <= 1'b0;
      dma_addr_q <= '0;
      dma_data_q <= '0;
    end else begin
      if (cpu_done) cpu_vld <= 1'b0;
      if ((!cpu_vld || cpu_done) && (cpu_rd_req || cpu_wr_en)) begin
        cpu_vld    <= 1'b1;
        cpu_wr_q   <= cpu_wr_en;
        cpu_addr_q <= cpu_addr;
        cpu_data_q <= cpu_wr_data;
      end
      if (dma_done) dma_vld <= 1'b0;
      if ((!dma_vld || dma_done) && (dma_rd_req || dma_wr_en)) begin
        dma_vld    <= 1'b1;
        dma_wr_q   <= dma_wr_en;
        dma_addr_q <= dma_addr;
        dma_data_q <= dma_wr_data;
      end
    end
  end

  // Bus FSM: arbitrate, issue one strobe, wait for ack or timeout, return read data
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      win_dma     <= 1'b0;
      run_cnt     <= '0;
      to_cnt      <= '0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      cpu_rd_data <= '0;
      dma_rd_data <= '0;
      grant_dma   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_vld || dma_vld) begin
            state     <= GRANT;
            to_cnt    <= '0;
            win_dma   <= pick_dma;
            grant_dma <= pick_dma;
            if (pick_dma) begin
              mem_addr    <= dma_addr_q;
              mem_wr_data <= dma_data_q;
              mem_wr_en   <= dma_wr_q;
              mem_rd_en   <= !dma_wr_q;
              run_cnt     <= cpu_vld ? run_cnt + 1'b1 : '0;
            end else begin
              mem_addr    <= cpu_addr_q;
              mem_wr_data <= cpu_data_q;
              mem_wr_en   <= cpu_wr_q;
              mem_rd_en   <= !cpu_wr_q;
              run_cnt     <= '0;
            end
          end else begin
            run_cnt <= '0;
          end
        end
        GRANT, WAIT_ACK: begin
          if (!cpu_pend) run_cnt <= '0;
          if (finish) begin
            state       <= IDLE;
            timeout_err <= timeout_hit;
            if (!win_wr) begin
              if (win_dma) dma_rd_data <= timeout_hit ? 8'hFF : mem_rd_data;
              else         cpu_rd_data <= timeout_hit ? 8'hFF : mem_rd_data;
            end
          end else begin
            state  <= WAIT_ACK;
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m6502_bus_arbiter.sv
// tb/tb_m6502_bus_arbiter.sv - directed scoreboard bench for m6502_bus_arbiter
module tb_m6502_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic        cpu_rd_req = 1'b0;
  logic        cpu_wr_en = 1'b0;
  logic [7:0]  cpu_wr_data = '0;
  logic [7:0]  cpu_rd_data;
  logic        cpu_ready;
  logic [15:0] dma_addr = '0;
  logic        dma_rd_req = 1'b0;
  logic        dma_wr_en = 1'b0;
  logic [7:0]  dma_wr_data = '0;
  logic [7:0]  dma_rd_data;
  logic        dma_ready;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_data;
  logic [7:0]  mem_rd_data = '0;
  logic        mem_ack = 1'b0;
  logic        grant_dma;
  logic        timeout_err;

  m6502_bus_arbiter #(.DMA_BURST_MAX(4), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_rd_req(cpu_rd_req), .cpu_wr_en(cpu_wr_en),
    .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data), .cpu_ready(cpu_ready),
    .dma_addr(dma_addr), .dma_rd_req(dma_rd_req), .dma_wr_en(dma_wr_en),
    .dma_wr_data(dma_wr_data), .dma_rd_data(dma_rd_data), .dma_ready(dma_ready),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_ack(mem_ack),
    .grant_dma(grant_dma), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dma;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_strobes = 0;
  int         ack_delay = 0;
  int         ack_cd = -1;
  logic       stray_ack = 1'b0;
  logic [7:0] rsp_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_strobe(input logic dma, input logic wr, input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.dma = dma;
    e.wr = wr;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    sample();
    while (!(cpu_ready && dma_ready) && n < 100) begin
      sample();
      n++;
    end
    check({tag, "_idle_in_time"}, n < 100, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_rd_en"}, mem_rd_en, 0);
    check({tag, "_mem_wr_en"}, mem_wr_en, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wr_data"}, mem_wr_data, 0);
    check({tag, "_cpu_rd_data"}, cpu_rd_data, 0);
    check({tag, "_dma_rd_data"}, dma_rd_data, 0);
    check({tag, "_cpu_ready"}, cpu_ready, 1);
    check({tag, "_dma_ready"}, dma_ready, 1);
    check({tag, "_grant_dma"}, grant_dma, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  // Memory model: ack a configurable number of cycles after each strobe (negative = never)
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_rd_en || mem_wr_en) ack_cd = ack_delay;
    else if (ack_cd > 0) ack_cd = ack_cd - 1;
    if (ack_cd == 0) begin
      mem_ack = 1'b1;
      ack_cd = -1;
    end
    if (stray_ack) mem_ack = 1'b1;
    mem_rd_data = rsp_data;
  end

  // Scoreboard: every strobe must match the oldest expected grant
  always @(negedge clk) begin
    if (mem_rd_en || mem_wr_en) begin
      n_strobes++;
      check("strobe_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("strobe_owner", grant_dma, mon_e.dma);
        check("strobe_wr", mem_wr_en, mon_e.wr);
        check("strobe_rd", mem_rd_en, !mon_e.wr);
        check("strobe_addr", mem_addr, mon_e.addr);
        if (mon_e.wr) check("strobe_wdata", mem_wr_data, mon_e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int base;

    repeat (3) step();
    sample();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();

    // Minimum-latency CPU read
    rsp_data = 8'hA5; ack_delay = 0; base = n_strobes;
    expect_strobe(1'b0, 1'b0, 16'h1234, 8'h00);
    cpu_addr = 16'h1234; cpu_rd_req = 1'b1;
    step();
    cpu_rd_req = 1'b0;
    sample();
    check("t1_ready_low_1", cpu_ready, 0);
    sample();
    check("t1_rd_en", mem_rd_en, 1);
    check("t1_addr", mem_addr, 16'h1234);
    check("t1_ready_low_2", cpu_ready, 0);
    sample();
    check("t1_ready_high", cpu_ready, 1);
    check("t1_rd_data", cpu_rd_data, 8'hA5);
    check("t1_strobe_low", mem_rd_en, 0);
    check("t1_strobes", n_strobes - base, 1);

    // Simultaneous CPU write and DMA read: DMA first
    step();
    rsp_data = 8'h5A; ack_delay = 1; base = n_strobes;
    expect_strobe(1'b1, 1'b0, 16'h8000, 8'h00);
    expect_strobe(1'b0, 1'b1, 16'h0200, 8'h3C);
    cpu_addr = 16'h0200; cpu_wr_data = 8'h3C; cpu_wr_en = 1'b1;
    dma_addr = 16'h8000; dma_rd_req = 1'b1;
    step();
    cpu_wr_en = 1'b0; dma_rd_req = 1'b0;
    wait_idle("t2");
    check("t2_strobes", n_strobes - base, 2);
    check("t2_dma_rd_data", dma_rd_data, 8'h5A);
    check("t2_grant_dma_last", grant_dma, 0);

    // DMA burst limit while a CPU read waits
    step();
    rsp_data = 8'h11; ack_delay = 0; base = n_strobes;
    for (int i = 0; i < 4; i++) expect_strobe(1'b1, 1'b0, 16'h9000, 8'h00);
    expect_strobe(1'b0, 1'b0, 16'h4000, 8'h00);
    expect_strobe(1'b1, 1'b0, 16'h9000, 8'h00);
    cpu_addr = 16'h4000; cpu_rd_req = 1'b1;
    dma_addr = 16'h9000; dma_rd_req = 1'b1;
    step();
    cpu_rd_req = 1'b0;
    k = 0;
    while (n_strobes - base < 6 && k < 100) begin
      sample();
      k++;
    end
    dma_rd_req = 1'b0;
    check("t3_six_grants_in_time", k < 100, 1);
    wait_idle("t3");
    check("t3_strobes", n_strobes - base, 6);
    check("t3_cpu_rd_data", cpu_rd_data, 8'h11);

    // Second CPU request while busy is dropped
    step();
    rsp_data = 8'hC3; ack_delay = 3; base = n_strobes;
    expect_strobe(1'b0, 1'b0, 16'h1111, 8'h00);
    cpu_addr = 16'h1111; cpu_rd_req = 1'b1;
    step();
    cpu_rd_req = 1'b0;
    step();
    cpu_addr = 16'h2222; cpu_rd_req = 1'b1;
    step();
    cpu_rd_req = 1'b0;
    sample();
    check("t5_mem_addr_held", mem_addr, 16'h1111);
    wait_idle("t5");
    check("t5_rd_data", cpu_rd_data, 8'hC3);
    check("t5_strobes", n_strobes - base, 1);
    check("t5_mem_addr_final", mem_addr, 16'h1111);

    // Ack timeout, then a stray late ack
    step();
    rsp_data = 8'h77; ack_delay = -1; base = n_strobes;
    expect_strobe(1'b0, 1'b0, 16'h3000, 8'h00);
    cpu_addr = 16'h3000; cpu_rd_req = 1'b1;
    step();
    cpu_rd_req = 1'b0;
    k = 0;
    sample();
    while (!mem_rd_en && k < 10) begin
      sample();
      k++;
    end
    check("t4_strobe_seen", mem_rd_en, 1);
    k = 0;
    do begin
      sample();
      k++;
    end while (!timeout_err && k < 40);
    check("t4_timeout_latency", k, 15);
    check("t4_rd_data_ff", cpu_rd_data, 8'hFF);
    check("t4_ready", cpu_ready, 1);
    sample();
    check("t4_pulse_width", timeout_err, 0);
    stray_ack = 1'b1;
    sample();
    sample();
    stray_ack = 1'b0;
    sample();
    check("t4_stray_rd_data", cpu_rd_data, 8'hFF);
    check("t4_stray_timeout", timeout_err, 0);
    check("t4_stray_ready", cpu_ready, 1);
    check("t4_strobes", n_strobes - base, 1);

    // Reset in WAIT_ACK with both ports pending
    step();
    ack_delay = -1; base = n_strobes;
    expect_strobe(1'b1, 1'b1, 16'h6666, 8'h99);
    cpu_addr = 16'h5555; cpu_rd_req = 1'b1;
    dma_addr = 16'h6666; dma_wr_data = 8'h99; dma_wr_en = 1'b1;
    step();
    cpu_rd_req = 1'b0; dma_wr_en = 1'b0;
    k = 0;
    sample();
    while (n_strobes == base && k < 10) begin
      sample();
      k++;
    end
    check("t6_strobe", n_strobes - base, 1);
    sample();
    sample();
    check("t6_both_busy", {cpu_ready, dma_ready}, 2'b00);
    reset = 1'b1;
    cpu_addr = 16'h7777; cpu_rd_req = 1'b1;
    step();
    cpu_rd_req = 1'b0;
    sample();
    check_reset_outputs("t6");
    reset = 1'b0;
    repeat (6) sample();
    check("t6_no_strobe", n_strobes - base, 1);
    check("t6_cpu_ready", cpu_ready, 1);
    check("t6_dma_ready", dma_ready, 1);
    step();
    rsp_data = 8'h3E; ack_delay = 0;
    expect_strobe(1'b1, 1'b0, 16'h0ABC, 8'h00);
    dma_addr = 16'h0ABC; dma_rd_req = 1'b1;
    step();
    dma_rd_req = 1'b0;
    wait_idle("t6_recover");
    check("t6_recover_rd_data", dma_rd_data, 8'h3E);
    check("t6_recover_grant", grant_dma, 1);
    check("t6_recover_strobes", n_strobes - base, 2);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
